// File: rtl/fetch_unit_pkg.sv
// +----------------------------------------------------------------------------+
// | fetch_unit_pkg                                                             |
// | Shared constants for the instruction fetch stage.                          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package fetch_unit_pkg;

    localparam int          INSN_W       = 16;
    localparam int          PC_STEP      = 2;
    localparam int          ADDR_W_DEF   = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

endpackage : fetch_unit_pkg

`default_nettype wire

// File: rtl/fetch_unit_fifo.sv
// +----------------------------------------------------------------------------+
// | fetch_fifo                                                                 |
// | Synchronous prefetch FIFO with clear, count and combinational head.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [CNT_W-1:0] o_count,
    output logic [WIDTH-1:0] o_head
);

    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != C_FULL) || w_do_pop);

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !i_clear && w_do_push) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

endmodule : fetch_fifo

`default_nettype wire

// File: rtl/fetch_unit.sv
// +----------------------------------------------------------------------------+
// | fetch_unit                                                                 |
// | PC owner and instruction prefetcher feeding decode over valid/ready.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                  DEPTH    = 4,
    parameter int                  ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0]   RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                halt,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                mem_ren,
    output logic [ADDR_W-2:0]   mem_raddr,
    input  logic [INSN_W-1:0]   mem_rdata,
    output logic                ins_valid,
    input  logic                ins_ready,
    output logic [INSN_W-1:0]   ins_data,
    output logic [ADDR_W-1:0]   ins_pc,
    output logic [ADDR_W-1:0]   fetch_pc
);

    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam int               ENTRY_W = INSN_W + ADDR_W;
    localparam logic [CNT_W:0]   C_DEPTH = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_req_pc;
    logic               r_inflight;
    logic               r_kill;

    logic [CNT_W-1:0]   w_count;
    logic [ENTRY_W-1:0] w_head;
    logic [CNT_W:0]     w_used;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;

    // Credits count both buffered words and the one still on its way back.
    assign w_used  = {1'b0, w_count} + (CNT_W + 1)'(r_inflight);
    assign w_issue = !reset && !halt && !redirect_valid && (w_used < C_DEPTH);
    assign w_push  = r_inflight && !r_kill;
    assign w_pop   = ins_valid && ins_ready && !redirect_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
        end else begin
            r_kill <= redirect_valid;
            if (redirect_valid) begin
                r_pc       <= {redirect_pc[ADDR_W-1:1], 1'b0};
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_req_pc <= r_pc;
                    r_pc     <= r_pc + ADDR_W'(PC_STEP);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (redirect_valid),
        .i_push      (w_push),
        .i_push_data ({mem_rdata, r_req_pc}),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    // Outputs read zero whenever the FIFO is empty so stale storage never leaks.
    assign ins_valid = (w_count != '0);
    assign ins_data  = ins_valid ? w_head[ENTRY_W-1:ADDR_W] : '0;
    assign ins_pc    = ins_valid ? w_head[ADDR_W-1:0]       : '0;

    assign mem_ren   = w_issue;
    assign mem_raddr = r_pc[ADDR_W-1:1];
    assign fetch_pc  = r_pc;

endmodule : fetch_unit

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | tb_fetch_unit                                                              |
// | Directed self-checking bench for fetch_unit with a 1-cycle memory model.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        mem_ren;
    logic [14:0] mem_raddr;
    logic [15:0] mem_rdata = 16'h0;
    logic        ins_valid;
    logic        ins_ready;
    logic [15:0] ins_data;
    logic [15:0] ins_pc;
    logic [15:0] fetch_pc;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit #(
        .DEPTH    (4),
        .ADDR_W   (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_ren        (mem_ren),
        .mem_raddr      (mem_raddr),
        .mem_rdata      (mem_rdata),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins_data       (ins_data),
        .ins_pc         (ins_pc),
        .fetch_pc       (fetch_pc)
    );

    always #5 clk = ~clk;

    // Memory returns word-address * 3 one cycle after a read.
    always @(posedge clk) begin
        if (mem_ren) begin
            mem_rdata <= ed({mem_raddr, 1'b0});
        end
    end

    function automatic logic [15:0] ed(input logic [15:0] pc);
        logic [31:0] t;
        t = {17'b0, pc[15:1]} * 32'd3;
        return t[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] p;
        reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; ins_ready = 1'b1;
        tick(); tick(); #1;
        chk("rst_valid", 32'(ins_valid), 0);
        chk("rst_data",  32'(ins_data),  0);
        chk("rst_pc",    32'(ins_pc),    0);
        chk("rst_fpc",   32'(fetch_pc),  0);
        chk("rst_ren",   32'(mem_ren),   0);

        tick(); reset = 1'b0; #1;
        chk("c0_ren",   32'(mem_ren),   1);
        chk("c0_raddr", 32'(mem_raddr), 0);
        tick(); #1;
        chk("c1_valid", 32'(ins_valid), 0);
        chk("c1_raddr", 32'(mem_raddr), 1);
        for (int k = 2; k <= 7; k++) begin
            tick(); #1;
            p = 16'(2 * (k - 2));
            chk("stream_valid", 32'(ins_valid), 1);
            chk("stream_pc",    32'(ins_pc),    32'(p));
            chk("stream_data",  32'(ins_data),  32'(ed(p)));
        end

        // Decode stalls: FIFO fills, head stays frozen.
        for (int k = 8; k <= 17; k++) begin
            tick(); ins_ready = 1'b0; #1;
            chk("stall_valid", 32'(ins_valid), 1);
            chk("stall_pc",    32'(ins_pc),    32'h000c);
            chk("stall_data",  32'(ins_data),  32'(ed(16'h000c)));
        end
        chk("full_ren", 32'(mem_ren),  0);
        chk("full_fpc", 32'(fetch_pc), 32'h0014);
        for (int k = 18; k <= 23; k++) begin
            tick(); ins_ready = 1'b1; #1;
            p = 16'(12 + 2 * (k - 18));
            chk("drain_valid", 32'(ins_valid), 1);
            chk("drain_pc",    32'(ins_pc),    32'(p));
            chk("drain_data",  32'(ins_data),  32'(ed(p)));
        end

        // Redirect with three words buffered.
        tick(); ins_ready = 1'b0; #1;
        chk("pre_rd_pc", 32'(ins_pc), 32'h0018);
        tick(); redirect_valid = 1'b1; redirect_pc = 16'h0101; #1;
        chk("rd_pc",  32'(ins_pc),  32'h0018);
        chk("rd_ren", 32'(mem_ren), 0);
        tick(); redirect_valid = 1'b0; ins_ready = 1'b1; #1;
        chk("rd1_valid", 32'(ins_valid), 0);
        chk("rd1_ren",   32'(mem_ren),   1);
        chk("rd1_raddr", 32'(mem_raddr), 32'h0080);
        chk("rd1_fpc",   32'(fetch_pc),  32'h0100);
        tick(); #1;
        chk("rd2_valid", 32'(ins_valid), 0);
        tick(); #1;
        chk("rd3_pc",   32'(ins_pc),   32'h0100);
        chk("rd3_data", 32'(ins_data), 32'(ed(16'h0100)));
        tick(); #1;
        chk("rd4_pc",   32'(ins_pc),   32'h0102);

        // Wrap around the top of the address space.
        tick(); redirect_valid = 1'b1; redirect_pc = 16'hfffc; #1;
        chk("wr0_pc", 32'(ins_pc), 32'h0104);
        tick(); redirect_valid = 1'b0; #1;
        chk("wr1_valid", 32'(ins_valid), 0);
        chk("wr1_raddr", 32'(mem_raddr), 32'h7ffe);
        tick(); #1;
        p = 16'hfffc;
        for (int k = 33; k <= 36; k++) begin
            tick(); #1;
            chk("wrap_valid", 32'(ins_valid), 1);
            chk("wrap_pc",    32'(ins_pc),    32'(p));
            chk("wrap_data",  32'(ins_data),  32'(ed(p)));
            p = p + 16'd2;
        end

        // Halt: outstanding word lands, FIFO drains, redirect while halted.
        tick(); halt = 1'b1; #1;
        chk("h0_ren", 32'(mem_ren), 0);
        chk("h0_pc",  32'(ins_pc),  32'h0004);
        tick(); #1;
        chk("h1_ren",   32'(mem_ren),   0);
        chk("h1_valid", 32'(ins_valid), 1);
        chk("h1_pc",    32'(ins_pc),    32'h0006);
        tick(); #1;
        chk("h2_valid", 32'(ins_valid), 0);
        chk("h2_fpc",   32'(fetch_pc),  32'h0008);
        chk("h2_ren",   32'(mem_ren),   0);
        tick(); redirect_valid = 1'b1; redirect_pc = 16'h0040; #1;
        chk("h3_ren", 32'(mem_ren), 0);
        tick(); redirect_valid = 1'b0; #1;
        chk("h4_ren", 32'(mem_ren),  0);
        chk("h4_fpc", 32'(fetch_pc), 32'h0040);
        tick(); halt = 1'b0; #1;
        chk("h5_ren",   32'(mem_ren),   1);
        chk("h5_raddr", 32'(mem_raddr), 32'h0020);
        tick(); #1;
        chk("h6_valid", 32'(ins_valid), 0);
        tick(); ins_ready = 1'b0; #1;
        chk("h7_pc",   32'(ins_pc),   32'h0040);
        chk("h7_data", 32'(ins_data), 32'h0060);

        // Reset with buffered words and a read in flight.
        tick(); #1;
        tick(); reset = 1'b1; #1;
        chk("r0_ren", 32'(mem_ren), 0);
        tick(); reset = 1'b0; #1;
        chk("r1_valid", 32'(ins_valid), 0);
        chk("r1_data",  32'(ins_data),  0);
        chk("r1_pc",    32'(ins_pc),    0);
        chk("r1_fpc",   32'(fetch_pc),  0);
        chk("r1_ren",   32'(mem_ren),   1);
        chk("r1_raddr", 32'(mem_raddr), 0);
        tick(); #1;
        chk("r2_valid", 32'(ins_valid), 0);
        tick(); #1;
        chk("r3_valid", 32'(ins_valid), 1);
        chk("r3_pc",    32'(ins_pc),    0);
        chk("r3_data",  32'(ins_data),  0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fetch_unit

`default_nettype wire
